// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, ALU/result-select encodings and the ID/EX record for the decode stage
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;
  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_t;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    alu_op_t         alu_op;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            branch;
    logic            jal;
    logic            jalr;
    result_src_t     result_src;
    logic            illegal;
  } id_ex_t;
  // alt selects SUB/SRA; callers mask it for the cases where bit 30 is not an op modifier
  function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/register_file.sv
// register_file: 32x32 2R1W register file, x0 hardwired to zero, write-through bypass
module register_file
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wd
);
  logic [31:0][XLEN-1:0] regs_q, regs_d;
  logic wr;
  assign wr = we && rd != 5'd0;
  always_comb begin
    regs_d = regs_q;
    if (wr) regs_d[rd] = wd;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) regs_q <= '0;
    else      regs_q <= regs_d;
  end
  assign rs1_data = rs1 == 5'd0 ? '0 : (wr && rd == rs1) ? wd : regs_q[rs1];
  assign rs2_data = rs2 == 5'd0 ? '0 : (wr && rd == rs2) ? wd : regs_q[rs2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with IF/ID and ID/EX registers, register file, immediate
// generator and control decoder; flush beats stall, stall injects a bubble.
module decode_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_current,
  input  logic [31:0]     inst,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_a,
  output logic            ex_alu_src_b,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_branch,
  output logic            ex_jal,
  output logic            ex_jalr,
  output logic [1:0]      ex_result_src,
  output logic            ex_illegal
);
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  id_ex_t id_ex_q, id_ex_d, dec;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0] f3;
  logic f7b5;
  register_file u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1      (if_inst_q[19:15]),
    .rs2      (if_inst_q[24:20]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_we),
    .rd       (wb_rd),
    .wd       (wb_data)
  );
  assign f3    = if_inst_q[14:12];
  assign f7b5  = if_inst_q[30];
  assign imm_i = {{20{if_inst_q[31]}}, if_inst_q[31:20]};
  assign imm_s = {{20{if_inst_q[31]}}, if_inst_q[31:25], if_inst_q[11:7]};
  assign imm_b = {{20{if_inst_q[31]}}, if_inst_q[7], if_inst_q[30:25], if_inst_q[11:8], 1'b0};
  assign imm_u = {if_inst_q[31:12], 12'b0};
  assign imm_j = {{12{if_inst_q[31]}}, if_inst_q[19:12], if_inst_q[20], if_inst_q[30:21], 1'b0};
  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = if_pc_q;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.rs1      = if_inst_q[19:15];
    dec.rs2      = if_inst_q[24:20];
    dec.rd       = if_inst_q[11:7];
    dec.funct3   = f3;
    case (if_inst_q[6:0])
      OP_OP: begin
        dec.alu_op    = alu_sel(f3, f7b5);
        dec.reg_write = 1'b1;
      end
      OP_IMM: begin
        dec.alu_op    = alu_sel(f3, f7b5 && f3 == 3'b101);
        dec.alu_src_b = 1'b1;
        dec.imm       = f3[1:0] == 2'b01 ? {27'b0, imm_i[4:0]} : imm_i;
        dec.reg_write = 1'b1;
      end
      OP_LUI: begin
        dec.alu_op    = ALU_PASSB;
        dec.alu_src_b = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec.alu_src_a = 1'b1;
        dec.alu_src_b = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        dec.alu_src_b  = 1'b1;
        dec.imm        = imm_i;
        dec.mem_read   = 1'b1;
        dec.result_src = RES_MEM;
        dec.reg_write  = 1'b1;
      end
      OP_STORE: begin
        dec.alu_src_b = 1'b1;
        dec.imm       = imm_s;
        dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.alu_op = ALU_SUB;
        dec.imm    = imm_b;
        dec.branch = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        dec.alu_src_a  = 1'b1;
        dec.alu_src_b  = 1'b1;
        dec.imm        = if_inst_q[3] ? imm_j : imm_i;
        dec.jal        = if_inst_q[3];
        dec.jalr       = !if_inst_q[3];
        dec.result_src = RES_PC4;
        dec.reg_write  = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.reg_write = dec.reg_write && dec.rd != 5'd0;
  end
  always_comb begin
    if_pc_d   = flush ? '0 : stall ? if_pc_q : pc_current;
    if_inst_d = flush ? NOP_INST : stall ? if_inst_q : inst;
    id_ex_d   = (flush || stall) ? '0 : dec;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_pc_q   <= '0;
      if_inst_q <= NOP_INST;
      id_ex_q   <= '0;
    end else begin
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
      id_ex_q   <= id_ex_d;
    end
  end
  assign ex_valid      = id_ex_q.valid;
  assign ex_pc         = id_ex_q.pc;
  assign ex_rs1_data   = id_ex_q.rs1_data;
  assign ex_rs2_data   = id_ex_q.rs2_data;
  assign ex_imm        = id_ex_q.imm;
  assign ex_rs1        = id_ex_q.rs1;
  assign ex_rs2        = id_ex_q.rs2;
  assign ex_rd         = id_ex_q.rd;
  assign ex_funct3     = id_ex_q.funct3;
  assign ex_alu_op     = id_ex_q.alu_op;
  assign ex_alu_src_a  = id_ex_q.alu_src_a;
  assign ex_alu_src_b  = id_ex_q.alu_src_b;
  assign ex_mem_read   = id_ex_q.mem_read;
  assign ex_mem_write  = id_ex_q.mem_write;
  assign ex_reg_write  = id_ex_q.reg_write;
  assign ex_branch     = id_ex_q.branch;
  assign ex_jal        = id_ex_q.jal;
  assign ex_jalr       = id_ex_q.jalr;
  assign ex_result_src = id_ex_q.result_src;
  assign ex_illegal    = id_ex_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table, hand sequences and random traffic checked
// against an instruction-level model of the decode stage.
module tb_decode_stage;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        src_a, src_b, mem_read, mem_write, reg_write, branch, jal, jalr;
    logic [1:0]  result_src;
    logic        illegal;
  } ex_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  res;
    logic [7:0]  flags;
    logic        ill;
  } vec_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] pc_current = '0, inst = NOP, wb_data = '0;
  logic stall = 1'b0, flush = 1'b0, wb_we = 1'b0;
  logic [4:0] wb_rd = '0;
  logic ex_valid, ex_alu_src_a, ex_alu_src_b, ex_mem_read, ex_mem_write, ex_reg_write;
  logic ex_branch, ex_jal, ex_jalr, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [3:0] ex_alu_op;
  logic [1:0] ex_result_src;
  int checks = 0, failures = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_inst;
  ex_t m_ex, dut;
  decode_stage u_dut (
    .clk(clk), .rst(rst), .pc_current(pc_current), .inst(inst), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op),
    .ex_alu_src_a(ex_alu_src_a), .ex_alu_src_b(ex_alu_src_b), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_result_src(ex_result_src), .ex_illegal(ex_illegal)
  );
  assign dut = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_funct3, ex_alu_op, ex_alu_src_a, ex_alu_src_b, ex_mem_read, ex_mem_write,
                ex_reg_write, ex_branch, ex_jal, ex_jalr, ex_result_src, ex_illegal};
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [161:0] act, input logic [161:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd7;
    return tbl[f3];
  endfunction
  // Decode from the ISA rules: immediates built arithmetically from sign and bit groups
  function automatic ex_t ref_decode(input logic [31:0] pc, input logic [31:0] in,
                                     input logic [31:0] r1, input logic [31:0] r2);
    ex_t e;
    logic [31:0] sx, ii, is, ib, iu, ij;
    sx = in[31] ? 32'hFFFF_FFFF : 32'h0;
    ii = 32'($signed(in) >>> 20);
    is = (sx << 12) | (32'(in[31:25]) << 5) | 32'(in[11:7]);
    ib = (sx << 12) | (32'(in[7]) << 11) | (32'(in[30:25]) << 5) | (32'(in[11:8]) << 1);
    iu = in & 32'hFFFF_F000;
    ij = (sx << 20) | (32'(in[19:12]) << 12) | (32'(in[20]) << 11) | (32'(in[30:21]) << 1);
    e = '0;
    e.valid = 1'b1; e.pc = pc; e.rs1_data = r1; e.rs2_data = r2;
    e.rs1 = in[19:15]; e.rs2 = in[24:20]; e.rd = in[11:7]; e.funct3 = in[14:12];
    case (in[6:0])
      7'h33: begin e.alu_op = alu_of(in[14:12], in[30]); e.reg_write = 1'b1; end
      7'h13: begin
        e.alu_op = alu_of(in[14:12], in[30] && in[14:12] == 3'd5);
        e.src_b = 1'b1; e.reg_write = 1'b1;
        e.imm = (in[14:12] == 3'd1 || in[14:12] == 3'd5) ? 32'(in[24:20]) : ii;
      end
      7'h37: begin e.alu_op = 4'd10; e.src_b = 1'b1; e.imm = iu; e.reg_write = 1'b1; end
      7'h17: begin e.src_a = 1'b1; e.src_b = 1'b1; e.imm = iu; e.reg_write = 1'b1; end
      7'h03: begin e.src_b = 1'b1; e.imm = ii; e.mem_read = 1'b1; e.result_src = 2'd1; e.reg_write = 1'b1; end
      7'h23: begin e.src_b = 1'b1; e.imm = is; e.mem_write = 1'b1; end
      7'h63: begin e.alu_op = 4'd1; e.imm = ib; e.branch = 1'b1; end
      7'h6F: begin e.src_a = 1'b1; e.src_b = 1'b1; e.imm = ij; e.jal = 1'b1; e.result_src = 2'd2; e.reg_write = 1'b1; end
      7'h67: begin e.src_a = 1'b1; e.src_b = 1'b1; e.imm = ii; e.jalr = 1'b1; e.result_src = 2'd2; e.reg_write = 1'b1; end
      7'h0F, 7'h73: ;
      default: e.illegal = 1'b1;
    endcase
    if (e.rd == 5'd0) e.reg_write = 1'b0;
    return e;
  endfunction
  task automatic model_reset();
    foreach (m_regs[k]) m_regs[k] = '0;
    m_pc = '0; m_inst = NOP; m_ex = '0;
  endtask
  // One clock edge: write-then-read regfile view gives the bypass for free
  task automatic step(input logic [31:0] p, input logic [31:0] i, input logic st, input logic fl,
                      input logic we, input logic [4:0] rd, input logic [31:0] d, input string nm);
    pc_current = p; inst = i; stall = st; flush = fl; wb_we = we; wb_rd = rd; wb_data = d;
    @(posedge clk);
    if (we && rd != 5'd0) m_regs[rd] = d;
    if (fl) begin
      m_ex = '0; m_pc = '0; m_inst = NOP;
    end else if (st) m_ex = '0;
    else begin
      m_ex = ref_decode(m_pc, m_inst, m_regs[m_inst[19:15]], m_regs[m_inst[24:20]]);
      m_pc = p; m_inst = i;
    end
    #1 chk(nm, dut, m_ex);
  endtask
  task automatic feed(input logic [31:0] p, input logic [31:0] i);
    step(p, i, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "pipe");
  endtask
  initial begin
    vec_t vt [14];
    logic [6:0] ops [13];
    logic [31:0] r;
    int n;
    vt = '{
      '{32'h00500093, 32'h00000005, 4'd0,  2'd0, 8'b01001000, 1'b0},
      '{32'hFE208CE3, 32'hFFFFFFF8, 4'd1,  2'd0, 8'b00000100, 1'b0},
      '{32'h010000EF, 32'h00000010, 4'd0,  2'd2, 8'b11001010, 1'b0},
      '{32'h0000007F, 32'h00000000, 4'd0,  2'd0, 8'b00000000, 1'b1},
      '{32'h40208133, 32'h00000000, 4'd1,  2'd0, 8'b00001000, 1'b0},
      '{32'h4030D093, 32'h00000003, 4'd7,  2'd0, 8'b01001000, 1'b0},
      '{32'hABCDE237, 32'hABCDE000, 4'd10, 2'd0, 8'b01001000, 1'b0},
      '{32'h00001517, 32'h00001000, 4'd0,  2'd0, 8'b11001000, 1'b0},
      '{32'hFFC12283, 32'hFFFFFFFC, 4'd0,  2'd1, 8'b01101000, 1'b0},
      '{32'h0050A423, 32'h00000008, 4'd0,  2'd0, 8'b01010000, 1'b0},
      '{32'h000080E7, 32'h00000000, 4'd0,  2'd2, 8'b11001001, 1'b0},
      '{32'h0000000F, 32'h00000000, 4'd0,  2'd0, 8'b00000000, 1'b0},
      '{32'h00500013, 32'h00000005, 4'd0,  2'd0, 8'b01000000, 1'b0},
      '{32'h00000073, 32'h00000000, 4'd0,  2'd0, 8'b00000000, 1'b0}
    };
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h0F, 7'h73, 7'h7F, 7'h00};
    model_reset();
    #2 chk("reset_state", dut, '0);
    @(posedge clk); #1 rst = 1'b1;
    // write-through bypass on rs1
    feed(32'h10, 32'h002081B3);
    step(32'h14, NOP, 1'b0, 1'b0, 1'b1, 5'd1, 32'hDEADBEEF, "bypass_step");
    chk("bypass_rs1", 32'(ex_rs1_data), 32'hDEADBEEF);
    // x0 write ignored
    feed(32'h18, 32'h000001B3);
    step(32'h1C, NOP, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, "x0_step");
    chk("x0_reads_zero", {ex_rs1_data, ex_rs2_data}, '0);
    feed(32'h20, 32'h002081B3);
    // asynchronous reset mid-cycle
    #2 rst = 1'b0;
    #1 chk("async_reset", dut, '0);
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    feed(32'h24, 32'h002081B3);
    feed(32'h28, NOP);
    chk("regs_cleared", 32'(ex_rs1_data), 32'h0);
    foreach (vt[k]) begin
      feed(32'h100 + 32'(k) * 4, vt[k].inst);
      feed(32'h800, NOP);
      chk($sformatf("vec%0d", k),
          {ex_imm, ex_alu_op, ex_result_src, ex_alu_src_a, ex_alu_src_b, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_branch, ex_jal, ex_jalr, ex_illegal, ex_valid},
          {vt[k].imm, vt[k].alu, vt[k].res, vt[k].flags, vt[k].ill, 1'b1});
    end
    // two stall cycles then release: held instruction issues once
    n = 0;
    feed(32'h300, 32'h00500093);
    step(32'h304, 32'h0000007F, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, "stall1");
    chk("stall1_bubble", 32'(ex_valid), 32'd0);
    step(32'h304, 32'h0000007F, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, "stall2");
    chk("stall2_bubble", 32'(ex_valid), 32'd0);
    feed(32'h308, NOP);
    if (ex_valid && ex_pc == 32'h300) n++;
    chk("stall_release", {ex_valid, ex_pc, ex_imm}, {1'b1, 32'h300, 32'd5});
    feed(32'h30C, NOP);
    if (ex_valid && ex_pc == 32'h300) n++;
    chk("issue_once", 32'(n), 32'd1);
    // flush wins over stall and leaves a NOP in IF/ID
    feed(32'h400, 32'h00500093);
    step(32'h404, 32'h002081B3, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, "flush_stall");
    chk("flush_bubble", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, '0);
    feed(32'h408, NOP);
    chk("flush_nop", {ex_valid, ex_pc, ex_imm, ex_rd, ex_alu_op, ex_alu_src_b},
        {1'b1, 32'h0, 32'h0, 5'd0, 4'd0, 1'b1});
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      step($urandom() & 32'hFFFF_FFFC, {r[31:7], ops[$urandom_range(0, 12)]},
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), $urandom(), $sformatf("rand%0d", c));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
